exc_cp0_unit: RTL and testbench
===============================

Name: exc_cp0_unit

Overview:
- Parametrised exception/CP0 unit at the MEM/commit boundary of the MIPS pipeline.
- Replaces the fixed 8-bit priority encoder with a configurable number of prioritised synchronous exception sources, each with a parametrised ExcCode.
- Also provides interrupt sampling, a Count/Compare timer, and architectural Status/Cause/EPC/BadVAddr/Count/Compare registers.
- Produces a registered flush and redirect PC for the pipeline.

Parameters:
- NUM_SRC, 7, number of synchronous exception request lines. Bit 0 has the highest priority.
- EXC_CODES, {5'd5,5'd4,5'd9,5'd8,5'd12,5'd10,5'd4}, packed 5-bit ExcCode per source. Source i uses bits [5i+4:5i].
- FETCH_SRC, 0, source index whose AdEL reports inst_pc as BadVAddr. Other AdEL/AdES sources report mem_addr.
- VEC_BASE, 32'hBFC00380, exception vector.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- hw_int  in  6  hardware interrupt lines, level
- inst_valid  in  1  committing instruction is valid
- inst_pc  in  32  PC of the committing instruction
- inst_in_ds  in  1  instruction is in a branch delay slot
- mem_addr  in  32  data address of a load/store
- exc_req  in  NUM_SRC  synchronous exception requests
- eret  in  1  committing instruction is ERET
- cp0_we  in  1  MTC0 write enable
- cp0_waddr  in  5  MTC0 register number
- cp0_wdata  in  32  MTC0 data
- cp0_raddr  in  5  MFC0 register number
- cp0_rdata  out  32  MFC0 data, combinational
- flush  out  1  pipeline flush, registered
- new_pc  out  32  redirect target, valid while flush=1
- exc_code  out  5  ExcCode of the last taken event
- status_o, cause_o, epc_o  out  32 each  register mirrors

Behaviour:
- Reset is rst, synchronous, active-high.
- Reset values:
  - Status=32'h00400000 (BEV=1); Cause, EPC, BadVAddr, Count, Compare = 0.
  - Timer flag ti=0; Count divider toggle=0.
  - flush=0, new_pc=0, exc_code=0.
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Unmapped addresses read 0.
- cp0_rdata is a combinational read of the current register state, with no write bypass.
- MTC0 writable fields:
  - Status IM[15:8], EXL[1], IE[0].
  - Cause IP[9:8] (software interrupts).
  - Count, Compare, EPC: full width.
  - BadVAddr: read-only.
  - All other bits are preserved.
- Cause.IP[15:10] <= hw_int every cycle.
- Cause.IP[15] = hw_int[5] | ti. Cause.TI[30] = ti.
- Timer:
  - Count increments on every second clock, via a toggle bit.
  - ti sets when Count == Compare, evaluated on the registered values.
  - Any MTC0 to Compare clears ti, and this clear wins over a same-cycle set.
  - MTC0 to Count overrides the increment.
- int_pend = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL.
- An event is taken only when inst_valid=1 and flush=0. The cycle after a flush is a shadow: inputs are ignored.
- Priority: interrupt (code 0) > exc_req[0] > ... > exc_req[NUM_SRC-1] > eret.
- On a taken exception or interrupt, at the next edge:
  - If Status.EXL was 0: EPC <= inst_in_ds ? inst_pc-4 : inst_pc, and Cause.BD <= inst_in_ds. If EXL was already 1, EPC and BD are unchanged.
  - Status.EXL <= 1. Cause.ExcCode <= code. exc_code <= code.
  - Code 4/5: BadVAddr <= (src==FETCH_SRC) ? inst_pc : mem_addr.
  - flush <= 1, new_pc <= VEC_BASE.
- On a taken ERET: Status.EXL <= 0, flush <= 1, new_pc <= EPC (value before any same-cycle write). exc_code is unchanged.
- An MTC0 in the same cycle as a taken event is discarded, because it belongs to the faulting instruction.
- An MTC0 in a non-event cycle applies at the next edge.
- flush is a one-cycle pulse. Two consecutive events cannot occur because of the shadow cycle.
- Interrupts are sampled only on a valid commit. A pending interrupt with inst_valid=0 is held, not lost.
- rst asserted mid-operation restores the reset values on the next edge. A flush in progress is dropped.

Test Plan:
1. exc_req=7'b0000100 (Ov) at inst_pc=0x80001000, in_ds=0, EXL=0 -> next cycle flush=1, new_pc=0xBFC00380; EPC=0x80001000; Cause[6:2]=12; Status.EXL=1; flush=0 the following cycle.
2. exc_req=7'b1000010 with in_ds=1, inst_pc=0x80002004, mem_addr=0x13 -> RI wins: ExcCode=10, EPC=0x80002000, BD=1, BadVAddr unchanged.
3. Load AdEL (exc_req[1]... src 5) with mem_addr=0x80000003 -> ExcCode=4, BadVAddr=0x80000003. Fetch AdEL (src 0) with inst_pc=0x80000002 -> BadVAddr=0x80000002.
4. Status=0x0000FF01, hw_int[2]=1, inst_valid=1, same cycle as Sys -> interrupt taken, ExcCode=0. With inst_valid=0 the interrupt is held until the next valid commit.
5. MTC0 Compare=10, Count=0 -> ti=1 and IP7=1 after 20 cycles. MTC0 Compare clears ti even when the match falls in the same cycle.
6. ERET with EPC=0x80003000 and same-cycle MTC0 EPC=0x1 -> new_pc=0x80003000, EXL=0, EPC still 0x80003000. Assert rst while flush=1 -> flush=0, Status=0x00400000.

Source files
------------

// File: rtl/exc_cp0_unit.sv
// Exception/CP0 unit at the MEM/commit boundary: prioritised exceptions, interrupts,
// Count/Compare timer, architectural CP0 registers and a registered flush/redirect.
module exc_cp0_unit #(
    parameter int                   NUM_SRC   = 7,
    parameter logic [5*NUM_SRC-1:0] EXC_CODES = {5'd5, 5'd4, 5'd9, 5'd8, 5'd12, 5'd10, 5'd4},
    parameter int                   FETCH_SRC = 0,
    parameter logic [31:0]          VEC_BASE  = 32'hBFC00380
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         hw_int,
    input  logic               inst_valid,
    input  logic [31:0]        inst_pc,
    input  logic               inst_in_ds,
    input  logic [31:0]        mem_addr,
    input  logic [NUM_SRC-1:0] exc_req,
    input  logic               eret,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_waddr,
    input  logic [31:0]        cp0_wdata,
    input  logic [4:0]         cp0_raddr,
    output logic [31:0]        cp0_rdata,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic [4:0]         exc_code,
    output logic [31:0]        status_o,
    output logic [31:0]        cause_o,
    output logic [31:0]        epc_o
);

    localparam logic [4:0] A_BADV    = 5'd8;
    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;

    // Status fields
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    // Cause fields
    logic        r_bd;
    logic        r_ti;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_code;
    // Remaining CP0 state
    logic [31:0] r_epc;
    logic [31:0] r_badv;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tog;
    // Pipeline redirect
    logic        r_flush;
    logic [31:0] r_new_pc;
    logic [4:0]  r_exc_code;

    logic [7:0]         w_ip;
    logic [31:0]        w_status;
    logic [31:0]        w_cause;
    logic               w_int_pend;
    logic               w_commit;
    logic               w_src_any;
    logic [NUM_SRC-1:0] w_src_oh;
    logic [4:0]         w_src_code;
    logic [4:0]         w_evt_code;
    logic               w_take_exc;
    logic               w_take_eret;
    logic               w_badv_upd;
    logic [31:0]        w_badv_val;
    logic [31:0]        w_epc_val;
    logic               w_wr;

    // The timer flag is folded into IP7 alongside hw_int[5].
    assign w_ip     = {r_ip_hw[5] | r_ti, r_ip_hw[4:0], r_ip_sw};
    assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {r_bd, r_ti, 14'd0, w_ip, 1'b0, r_code, 2'b00};

    assign w_int_pend = (|(w_ip & r_im)) & r_ie & ~r_exl;
    assign w_commit   = inst_valid & ~r_flush;

    // Lowest-numbered request wins.
    always_comb begin
        w_src_oh   = '0;
        w_src_code = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (exc_req[i]) begin
                w_src_oh    = '0;
                w_src_oh[i] = 1'b1;
                w_src_code  = EXC_CODES[5*i +: 5];
            end
        end
    end

    assign w_src_any   = |exc_req;
    assign w_take_exc  = w_commit & (w_int_pend | w_src_any);
    assign w_take_eret = w_commit & ~w_int_pend & ~w_src_any & eret;
    assign w_evt_code  = w_int_pend ? 5'd0 : w_src_code;
    assign w_badv_upd  = ~w_int_pend & ((w_src_code == 5'd4) | (w_src_code == 5'd5));
    assign w_badv_val  = w_src_oh[FETCH_SRC] ? inst_pc : mem_addr;
    assign w_epc_val   = inst_in_ds ? (inst_pc - 32'd4) : inst_pc;

    // MTC0 from a faulting/ERET instruction or from the shadow slot never lands.
    assign w_wr = cp0_we & ~r_flush & ~w_take_exc & ~w_take_eret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip_hw    <= '0;
            r_ip_sw    <= '0;
            r_code     <= '0;
            r_epc      <= '0;
            r_badv     <= '0;
            r_exc_code <= '0;
        end else begin
            r_ip_hw <= hw_int;
            if (w_take_exc) begin
                if (!r_exl) begin
                    r_epc <= w_epc_val;
                    r_bd  <= inst_in_ds;
                end
                r_exl      <= 1'b1;
                r_code     <= w_evt_code;
                r_exc_code <= w_evt_code;
                if (w_badv_upd)
                    r_badv <= w_badv_val;
            end else if (w_take_eret) begin
                r_exl <= 1'b0;
            end else if (w_wr) begin
                case (cp0_waddr)
                    A_STATUS: begin
                        r_im  <= cp0_wdata[15:8];
                        r_exl <= cp0_wdata[1];
                        r_ie  <= cp0_wdata[0];
                    end
                    A_CAUSE: r_ip_sw <= cp0_wdata[9:8];
                    A_EPC:   r_epc   <= cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Count ticks at half the clock rate; a Compare write always beats a match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tog     <= 1'b0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_tog <= ~r_tog;
            if (w_wr && cp0_waddr == A_COUNT)
                r_count <= cp0_wdata;
            else if (r_tog)
                r_count <= r_count + 32'd1;
            if (w_wr && cp0_waddr == A_COMPARE) begin
                r_compare <= cp0_wdata;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush  <= 1'b0;
            r_new_pc <= '0;
        end else begin
            r_flush <= w_take_exc | w_take_eret;
            if (w_take_exc)
                r_new_pc <= VEC_BASE;
            else if (w_take_eret)
                r_new_pc <= r_epc;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            A_BADV:    cp0_rdata = r_badv;
            A_COUNT:   cp0_rdata = r_count;
            A_COMPARE: cp0_rdata = r_compare;
            A_STATUS:  cp0_rdata = w_status;
            A_CAUSE:   cp0_rdata = w_cause;
            A_EPC:     cp0_rdata = r_epc;
            default:   cp0_rdata = '0;
        endcase
    end

    assign flush    = r_flush;
    assign new_pc   = r_new_pc;
    assign exc_code = r_exc_code;
    assign status_o = w_status;
    assign cause_o  = w_cause;
    assign epc_o    = r_epc;

endmodule

// File: tb/tb_exc_cp0_unit.sv
// Randomised + directed bench for exc_cp0_unit against an architectural CP0 model.
module tb_exc_cp0_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        inst_in_ds;
    logic [31:0] mem_addr;
    logic [6:0]  exc_req;
    logic        eret;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] new_pc;
    logic [4:0]  exc_code;
    logic [31:0] status_o, cause_o, epc_o;

    always #5 clk = ~clk;

    exc_cp0_unit dut (
        .clk(clk), .rst(rst), .hw_int(hw_int), .inst_valid(inst_valid),
        .inst_pc(inst_pc), .inst_in_ds(inst_in_ds), .mem_addr(mem_addr),
        .exc_req(exc_req), .eret(eret), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .flush(flush), .new_pc(new_pc), .exc_code(exc_code),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Architectural model: whole 32-bit register words; Cause holds BD/ExcCode/IP[9:8],
    // the sampled hw lines and the timer flag are merged in on read.
    int          m_codes[7] = '{4, 10, 12, 8, 9, 4, 5};
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare, m_newpc;
    logic [5:0]  m_hw;
    logic        m_ti, m_tog, m_flush;
    logic [4:0]  m_exc;

    function automatic logic [31:0] m_cause_rd();
        return m_cause | {1'b0, m_ti, 14'd0, m_hw[5] | m_ti, m_hw[4:0], 10'd0};
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause_rd();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_status = 32'h00400000; m_cause = 0; m_epc = 0; m_badv = 0;
        m_count = 0; m_compare = 0; m_newpc = 0; m_hw = 0;
        m_ti = 0; m_tog = 0; m_flush = 0; m_exc = 0;
    endtask

    task automatic m_update();
        logic [31:0] ip, n_status, n_cause, n_epc, n_badv, n_count, n_compare, n_newpc;
        logic        pend, is_exc, is_eret, n_ti, n_flush;
        int          src, code;
        logic [4:0]  n_exc;
        if (rst) begin
            m_reset();
            return;
        end
        ip   = m_cause_rd();
        pend = (|(ip[15:8] & m_status[15:8])) && m_status[0] && !m_status[1];
        is_exc = 0; is_eret = 0; src = -1; code = 0;
        if (inst_valid && !m_flush) begin
            for (int i = 0; i < 7; i++)
                if (exc_req[i] && src < 0) src = i;
            if (pend) begin
                is_exc = 1; code = 0; src = -1;
            end else if (src >= 0) begin
                is_exc = 1; code = m_codes[src];
            end else if (eret) begin
                is_eret = 1;
            end
        end
        n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_badv = m_badv;
        n_compare = m_compare; n_newpc = m_newpc; n_exc = m_exc;
        n_count = m_tog ? m_count + 32'd1 : m_count;
        n_ti    = m_ti || (m_count == m_compare);
        n_flush = is_exc || is_eret;
        if (is_exc) begin
            if (!m_status[1]) begin
                n_epc = inst_in_ds ? inst_pc - 32'd4 : inst_pc;
                n_cause[31] = inst_in_ds;
            end
            n_status[1]  = 1'b1;
            n_cause[6:2] = 5'(code);
            n_exc        = 5'(code);
            if (code == 4 || code == 5)
                n_badv = (src == 0) ? inst_pc : mem_addr;
            n_newpc = 32'hBFC00380;
        end else if (is_eret) begin
            n_status[1] = 1'b0;
            n_newpc     = m_epc;
        end else if (cp0_we && !m_flush) begin
            case (cp0_waddr)
                5'd9:  n_count = cp0_wdata;
                5'd11: begin n_compare = cp0_wdata; n_ti = 1'b0; end
                5'd12: n_status = (m_status & ~32'h0000FF03) | (cp0_wdata & 32'h0000FF03);
                5'd13: n_cause  = (m_cause & ~32'h00000300) | (cp0_wdata & 32'h00000300);
                5'd14: n_epc    = cp0_wdata;
                default: ;
            endcase
        end
        m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badv = n_badv;
        m_count = n_count; m_compare = n_compare; m_newpc = n_newpc; m_exc = n_exc;
        m_ti = n_ti; m_flush = n_flush; m_hw = hw_int; m_tog = ~m_tog;
    endtask

    // One cycle: inputs already set at the falling edge.
    task automatic step();
        #1;
        chk("rdata", cp0_rdata, m_rd(cp0_raddr));
        m_update();
        @(posedge clk);
        @(negedge clk);
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        if (m_flush) chk("new_pc", new_pc, m_newpc);
        chk("exc_code", {27'd0, exc_code}, {27'd0, m_exc});
        chk("status", status_o, m_status);
        chk("cause", cause_o, m_cause_rd());
        chk("epc", epc_o, m_epc);
    endtask

    task automatic idle();
        rst = 0; hw_int = 0; inst_valid = 0; inst_pc = 0; inst_in_ds = 0; mem_addr = 0;
        exc_req = 0; eret = 0; cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        inst_valid = 1; cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
        step();
        idle();
    endtask

    logic [4:0] waddrs[6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};

    initial begin
        logic [31:0] r;
        idle();
        cp0_raddr = 5'd12;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        m_reset();
        step();
        chk("rst_status", status_o, 32'h00400000);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        rst = 0;

        // Ov at EXL=0
        inst_valid = 1; inst_pc = 32'h80001000; exc_req = 7'b0000100;
        step();
        chk("t1_newpc", new_pc, 32'hBFC00380);
        chk("t1_code", {27'd0, cause_o[6:2]}, 32'd12);
        chk("t1_epc", epc_o, 32'h80001000);
        idle(); step();
        chk("t1_pulse", {31'd0, flush}, 32'd0);
        mtc0(5'd12, 32'd0);

        // RI beats AdES, delay slot
        inst_valid = 1; inst_in_ds = 1; inst_pc = 32'h80002004; mem_addr = 32'h13;
        exc_req = 7'b1000010;
        step();
        chk("t2_code", {27'd0, exc_code}, 32'd10);
        chk("t2_epc", epc_o, 32'h80002000);
        idle(); cp0_raddr = 5'd8; step();
        mtc0(5'd12, 32'd0);

        // Load AdEL then fetch AdEL
        inst_valid = 1; mem_addr = 32'h80000003; exc_req = 7'b0100000;
        step();
        idle(); step();
        chk("t3_badv_ld", cp0_rdata, 32'h80000003);
        mtc0(5'd12, 32'd0);
        inst_valid = 1; inst_pc = 32'h80000002; mem_addr = 32'h55; exc_req = 7'b0000001;
        step();
        idle(); step();
        chk("t3_badv_if", cp0_rdata, 32'h80000002);
        mtc0(5'd12, 32'd0);

        // ERET with same-cycle MTC0 EPC, then reset during the flush
        mtc0(5'd14, 32'h80003000);
        inst_valid = 1; eret = 1; cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h1;
        step();
        chk("t6_newpc", new_pc, 32'h80003000);
        chk("t6_epc", epc_o, 32'h80003000);
        idle(); rst = 1; step();
        chk("t6_rst_flush", {31'd0, flush}, 32'd0);
        chk("t6_rst_status", status_o, 32'h00400000);
        idle();

        // Timer match and Compare-write precedence
        cp0_raddr = 5'd9;
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        repeat (22) step();
        chk("t5_ti", {31'd0, cause_o[30]}, 32'd1);
        chk("t5_ip7", {31'd0, cause_o[15]}, 32'd1);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd4);
        for (int k = 0; k < 20 && m_count != m_compare; k++) step();
        mtc0(5'd11, 32'hFFFF0000);
        chk("t5_clr", {31'd0, cause_o[30]}, 32'd0);

        // Interrupt beats Sys; held across invalid cycles
        mtc0(5'd12, 32'h0000FF01);
        idle(); hw_int = 6'b000100;
        repeat (3) step();
        chk("t4_held", {31'd0, flush}, 32'd0);
        inst_valid = 1; exc_req = 7'b0001000;
        step();
        chk("t4_code", {27'd0, exc_code}, 32'd0);
        idle(); step();
        mtc0(5'd12, 32'd0);

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            rst        = (r[9:0] == 10'd7);
            inst_valid = (r[11:10] != 2'b00);
            inst_in_ds = r[12];
            exc_req    = (r[14:13] == 2'b00) ? r[21:15] : 7'd0;
            eret       = (r[24:22] == 3'd0);
            hw_int     = (r[27:25] == 3'd0) ? 6'($urandom) : 6'd0;
            cp0_we     = inst_valid && !m_flush && (r[29:28] == 2'b00);
            cp0_waddr  = r[30] ? waddrs[$urandom_range(0, 5)] : 5'($urandom);
            cp0_wdata  = $urandom;
            cp0_raddr  = r[31] ? waddrs[$urandom_range(0, 5)] : 5'($urandom);
            r = $urandom;
            inst_pc    = {r[31:2], 2'b00} ^ {30'd0, r[1:0] & {2{r[5]}}};
            mem_addr   = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
